// File: rtl/seg_window_driver.sv
// -----------------------------------------------------------------------------
// seg_window_driver
//
// Purpose:
//   Time-multiplexes a 4-digit, common-anode 7-segment display (active-low
//   anodes and segments). It shows a 4-digit window of six 4-bit digit codes,
//   and view_mode selects the window. The digits and the mode are captured
//   only at frame boundaries, so a frame is never torn. Each digit slot begins
//   with a short all-anodes-off gap that suppresses ghosting. The decimal
//   point on the rightmost digit lights when the window is scrolled away
//   from d0.
//
// Parameters:
//   REFRESH_DIV  - clock cycles per digit slot (>= 4)
//   BLANK_CYCLES - leading cycles of each slot with all anodes off (< REFRESH_DIV)
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous reset, active-low (release is synchronous)
//   digits     in   24  packed codes, d0 = digits[3:0] ... d5 = digits[23:20]
//   view_mode  in   2   00: d0..d3, 01: d1..d4, 10: d2..d5, 11: as 00
//   an         out  4   anode enables, active-low, an[0] = rightmost digit
//   seg        out  7   segments gfedcba, active-low
//   dp         out  1   decimal point, active-low
// -----------------------------------------------------------------------------
module seg_window_driver #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] digits,
  input  logic [1:0]  view_mode,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);

  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Scan state
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_slot;

  // Frame snapshot of the inputs
  logic [23:0]      r_snap_digits;
  logic [1:0]       r_snap_mode;
  logic             r_load_pending;

  // Registered outputs
  logic [3:0]       r_an;
  logic [6:0]       r_seg;
  logic             r_dp;

  logic             w_cnt_wrap;
  logic             w_load;
  logic [1:0]       w_off;
  logic [2:0]       w_idx;
  logic [3:0]       w_code;
  logic [6:0]       w_seg_dec;
  logic             w_blank;
  logic [3:0]       w_an_sel;
  logic [3:0]       w_snap_d [6];

  // Unpack the snapshot into individual digit codes.
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_unpack
      assign w_snap_d[gi] = r_snap_digits[gi*4 +: 4];
    end
    // Active-low one-hot anode select for the current slot.
    for (gi = 0; gi < 4; gi++) begin : g_an
      assign w_an_sel[gi] = (r_slot != 2'(gi));
    end
  endgenerate

  assign w_cnt_wrap = (r_cnt == CNT_MAX);
  // Capture at the last cycle of slot 3, or on the first edge after reset.
  assign w_load     = (w_cnt_wrap && (r_slot == 2'd3)) || r_load_pending;
  // Mode 11 is treated as 00.
  assign w_off      = (r_snap_mode == 2'b11) ? 2'd0 : r_snap_mode;
  // slot <= 3 and off <= 2, so the index stays within 0..5.
  assign w_idx      = {1'b0, r_slot} + {1'b0, w_off};
  assign w_code     = w_snap_d[w_idx];
  assign w_blank    = (r_cnt < BLANK_LIM);

  always_comb begin
    w_seg_dec = SEG_OFF;
    case (w_code)
      4'd0:    w_seg_dec = 7'h40;
      4'd1:    w_seg_dec = 7'h79;
      4'd2:    w_seg_dec = 7'h24;
      4'd3:    w_seg_dec = 7'h30;
      4'd4:    w_seg_dec = 7'h19;
      4'd5:    w_seg_dec = 7'h12;
      4'd6:    w_seg_dec = 7'h02;
      4'd7:    w_seg_dec = 7'h78;
      4'd8:    w_seg_dec = 7'h00;
      4'd9:    w_seg_dec = 7'h10;
      4'd10:   w_seg_dec = 7'h3F;   // minus sign
      default: w_seg_dec = SEG_OFF; // blank
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt          <= '0;
      r_slot         <= 2'd0;
      r_snap_digits  <= 24'd0;
      r_snap_mode    <= 2'b00;
      r_load_pending <= 1'b1;
      r_an           <= AN_OFF;
      r_seg          <= SEG_OFF;
      r_dp           <= 1'b1;
    end else begin
      if (w_cnt_wrap) begin
        r_cnt  <= '0;
        r_slot <= r_slot + 2'd1;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
      end

      if (w_load) begin
        r_snap_digits  <= digits;
        r_snap_mode    <= view_mode;
        r_load_pending <= 1'b0;
      end

      // Outputs reflect this cycle's scan state and snapshot.
      if (w_blank) begin
        r_an  <= AN_OFF;
        r_seg <= SEG_OFF;
        r_dp  <= 1'b1;
      end else begin
        r_an  <= w_an_sel;
        r_seg <= w_seg_dec;
        r_dp  <= !((r_slot == 2'd0) && (w_off != 2'd0));
      end
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule

// File: tb/tb_seg_window_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_window_driver
//
// Directed bench for seg_window_driver with REFRESH_DIV=8 and BLANK_CYCLES=2.
// Each step queues the expected per-cycle {an, seg, dp}. The queue is then
// drained one clock at a time and compared 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_seg_window_driver;

  localparam int RD = 8;
  localparam int BC = 2;
  localparam logic [11:0] BLANK = {4'b1111, 7'h7F, 1'b1};

  logic        clk;
  logic        rst_n;
  logic [23:0] digits;
  logic [1:0]  view_mode;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  string cur_tag = "init";
  logic [11:0] exp_q [$];

  seg_window_driver #(
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .digits   (digits),
    .view_mode(view_mode),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cyc=%0d: observed an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
             tag, cycle, obs[11:8], obs[7:1], obs[0], expv[11:8], expv[7:1], expv[0]);
    end
    $display("check %s cyc=%0d an=%b seg=%h dp=%b", tag, cycle, obs[11:8], obs[7:1], obs[0]);
  endtask

  // Expected outputs for one full digit slot: blanking gap then the digit.
  task automatic push_slot(input int slot, input logic [6:0] segv, input logic dpv);
    logic [3:0] a;
    a = 4'b1111;
    a[slot] = 1'b0;
    for (int i = 0; i < BC; i++) exp_q.push_back(BLANK);
    for (int i = BC; i < RD; i++) exp_q.push_back({a, segv, dpv});
  endtask

  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3,
                            input logic dp0);
    push_slot(0, s0, dp0);
    push_slot(1, s1, 1'b1);
    push_slot(2, s2, 1'b1);
    push_slot(3, s3, 1'b1);
  endtask

  // One comparison per queued entry, each on a fresh clock.
  task automatic drain();
    logic [11:0] e;
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1;
      cycle++;
      e = exp_q.pop_front();
      check(cur_tag, {an, seg, dp}, e);
    end
  endtask

  // Hold reset for two edges, check the reset outputs, release at a falling edge.
  task automatic do_reset(input logic [23:0] d, input logic [1:0] m);
    rst_n     = 1'b0;
    digits    = d;
    view_mode = m;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {an, seg, dp}, BLANK);
    @(negedge clk);
    rst_n = 1'b1;
    cycle = 0;
  endtask

  initial begin
    rst_n     = 1'b0;
    digits    = 24'h0;
    view_mode = 2'b00;

    // 1: mode 00 shows d0..d3
    cur_tag = "t1_mode00";
    do_reset(24'h543210, 2'b00);
    push_frame(7'h40, 7'h79, 7'h24, 7'h30, 1'b1);
    drain();

    // 2: mode 10 shows d2..d5, dp lit on slot 0
    cur_tag = "t2_mode10";
    do_reset(24'h543210, 2'b10);
    push_frame(7'h24, 7'h30, 7'h19, 7'h12, 1'b0);
    drain();

    // 3: mode change during slot 1 only takes effect next frame
    cur_tag = "t3_slot0";
    do_reset(24'h543210, 2'b00);
    push_slot(0, 7'h40, 1'b1);
    drain();
    view_mode = 2'b01;
    cur_tag = "t3_oldwin";
    push_slot(1, 7'h79, 1'b1);
    push_slot(2, 7'h24, 1'b1);
    push_slot(3, 7'h30, 1'b1);
    drain();
    cur_tag = "t3_newwin";
    push_frame(7'h79, 7'h24, 7'h30, 7'h19, 1'b0);
    drain();

    // 4: minus sign and blank codes
    cur_tag = "t4_codes";
    do_reset(24'hFFFFAA, 2'b00);
    push_frame(7'h3F, 7'h3F, 7'h7F, 7'h7F, 1'b1);
    drain();

    // 5: mode 11 behaves as 00
    cur_tag = "t5_mode11";
    do_reset(24'h543210, 2'b11);
    push_frame(7'h40, 7'h79, 7'h24, 7'h30, 1'b1);
    push_frame(7'h40, 7'h79, 7'h24, 7'h30, 1'b1);
    drain();

    // 6: asynchronous reset in slot 2, then a fresh snapshot on the first edge
    cur_tag = "t6_pre";
    do_reset(24'h543210, 2'b00);
    push_slot(0, 7'h40, 1'b1);
    push_slot(1, 7'h79, 1'b1);
    exp_q.push_back(BLANK);
    exp_q.push_back(BLANK);
    exp_q.push_back({4'b1011, 7'h24, 1'b1});
    drain();
    rst_n  = 1'b0;
    #1;
    check("t6_async_rst", {an, seg, dp}, BLANK);
    digits = 24'h000987;
    @(negedge clk);
    rst_n  = 1'b1;
    cycle  = 0;
    cur_tag = "t6_post";
    exp_q.push_back(BLANK);
    drain();
    digits = 24'h543210;  // after the first edge: must not be captured
    exp_q.push_back(BLANK);
    for (int i = BC; i < RD; i++) exp_q.push_back({4'b1110, 7'h78, 1'b1});
    push_slot(1, 7'h00, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety bound on total run time.
  initial begin
    #200000;
    $display("FAIL timeout: observed no completion, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
